// File: rtl/dco_lock_pkg.sv
// rtl/dco_lock_pkg.sv - shared types and widths for the DCO acquisition sequencer
package dco_lock_pkg;
  localparam int CW_W   = 13;
  localparam int SAR_W  = 10;
  localparam int FRAC_W = 3;

  localparam logic [CW_W-1:0]   CW_MIDSCALE = 13'd4096;
  localparam logic [SAR_W-1:0]  SAR_START   = 10'h200;
  localparam logic [FRAC_W-1:0] FRAC_ZERO   = '0;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, TRACK} dco_lock_state_t;
endpackage

// File: rtl/dco_lock_det.sv
// rtl/dco_lock_det.sv - bang-bang dither detector: counts consecutive alternating
// detector samples and raises a sticky lock flag at LOCK_CNT
module dco_lock_det #(
  parameter int LOCK_CNT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic fd_valid,
  input  logic fd_fast,
  output logic locked
);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             prev_fast;

  // A zero count marks "no sample since entry", so no separate first flag is needed.
  always_comb begin
    cnt_next = cnt;
    if (cnt == '0) begin
      cnt_next = CNT_ONE;
    end else if (fd_fast != prev_fast) begin
      if (cnt != CNT_MAX) cnt_next = cnt + CNT_ONE;
    end else begin
      cnt_next = CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt       <= '0;
      prev_fast <= 1'b0;
      locked    <= 1'b0;
    end else if (fd_valid) begin
      cnt       <= cnt_next;
      prev_fast <= fd_fast;
      if (cnt_next == CNT_MAX) locked <= 1'b1;
    end
  end
endmodule

// File: rtl/dco_lock_ctrl.sv
// rtl/dco_lock_ctrl.sv - DCO acquisition sequencer: SAR coarse search, loop-filter handoff, lock track
// Optional DCO_LOCK_RELOCK_EN: loop-filter saturation in TRACK restarts the coarse search.
module dco_lock_ctrl
  import dco_lock_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_CNT   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            fd_valid,
  input  logic            fd_fast,
  input  logic [CW_W-1:0] lf_word,
  output logic [CW_W-1:0] ctrl_word,
  output logic            lf_preset,
  output logic [CW_W-1:0] lf_preset_val,
  output logic            lf_en,
  output logic            busy,
  output logic            locked
);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);

  dco_lock_state_t  state;
  logic [SAR_W-1:0] sar;
  logic [SAR_W-1:0] sar_next;
  logic [3:0]       bit_idx;
  logic [SET_W-1:0] settle_cnt;
  logic             meas_done;
  logic             final_bit;
  logic             relock;

  assign meas_done = (state == MEASURE) && fd_valid;
  assign final_bit = meas_done && (bit_idx == 4'd0);

`ifdef DCO_LOCK_RELOCK_EN
  assign relock = (state == TRACK) && ((lf_word == '0) || (lf_word == '1));
`else
  assign relock = 1'b0;
`endif

  // Decide the current bit and arm the next one in a single step.
  always_comb begin
    sar_next = sar;
    if (fd_fast) sar_next[bit_idx] = 1'b0;
    if (bit_idx != 4'd0) sar_next[bit_idx - 4'd1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ctrl_word     <= CW_MIDSCALE;
      lf_preset     <= 1'b0;
      lf_preset_val <= '0;
      lf_en         <= 1'b0;
      busy          <= 1'b0;
      sar           <= '0;
      bit_idx       <= 4'd0;
      settle_cnt    <= '0;
    end else begin
      lf_preset <= 1'b0;
      if (((state == IDLE) && start) || relock) begin
        state      <= SETTLE;
        sar        <= SAR_START;
        bit_idx    <= 4'd9;
        settle_cnt <= '0;
        ctrl_word  <= {SAR_START, FRAC_ZERO};
        busy       <= 1'b1;
        lf_en      <= 1'b0;
      end else begin
        case (state)
          SETTLE: begin
            settle_cnt <= settle_cnt + SETTLE_ONE;
            if (settle_cnt == SETTLE_LAST) state <= MEASURE;
          end
          MEASURE: begin
            if (fd_valid) begin
              sar       <= sar_next;
              ctrl_word <= {sar_next, FRAC_ZERO};
              if (bit_idx != 4'd0) begin
                bit_idx    <= bit_idx - 4'd1;
                settle_cnt <= '0;
                state      <= SETTLE;
              end else begin
                state         <= TRACK;
                busy          <= 1'b0;
                lf_en         <= 1'b1;
                lf_preset     <= 1'b1;
                lf_preset_val <= {sar_next, FRAC_ZERO};
              end
            end
          end
          TRACK:   ctrl_word <= lf_word;
          default: ;
        endcase
      end
    end
  end

  dco_lock_det #(.LOCK_CNT(LOCK_CNT)) u_det (
    .clk      (clk),
    .rst      (rst),
    .clear    (final_bit || relock),
    .fd_valid (fd_valid && (state == TRACK)),
    .fd_fast  (fd_fast),
    .locked   (locked)
  );
endmodule

// File: tb/tb_dco_lock_ctrl.sv
// tb/tb_dco_lock_ctrl.sv - self-checking bench for dco_lock_ctrl
module tb_dco_lock_ctrl;
  localparam int SC = 4;
  localparam int LC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        fd_valid = 1'b0;
  logic        fd_fast = 1'b0;
  logic [12:0] lf_word = 13'd100;
  logic [12:0] ctrl_word;
  logic        lf_preset;
  logic [12:0] lf_preset_val;
  logic        lf_en;
  logic        busy;
  logic        locked;

  int n_checks = 0;
  int n_errors = 0;
  int n_preset = 0;
  bit pat_q[$];

  typedef struct {
    int target;
    int exp_preset;
  } vec_t;

  vec_t vecs[8];
  int   seq677[10];

  dco_lock_ctrl #(.SETTLE_CYC(SC), .LOCK_CNT(LC)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .fd_valid      (fd_valid),
    .fd_fast       (fd_fast),
    .lf_word       (lf_word),
    .ctrl_word     (ctrl_word),
    .lf_preset     (lf_preset),
    .lf_preset_val (lf_preset_val),
    .lf_en         (lf_en),
    .busy          (busy),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (lf_preset === 1'b1) n_preset++;
  endtask

  // Binary-search trial k: bits of the target above the trial bit, plus the trial bit.
  function automatic int trial(input int t, input int k);
    int sh;
    sh = 10 - k;
    return ((t >> sh) << sh) | (1 << (9 - k));
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl_word"}, ctrl_word, 4096);
    chk({tag, "_lf_preset"}, lf_preset, 0);
    chk({tag, "_lf_preset_val"}, lf_preset_val, 0);
    chk({tag, "_lf_en"}, lf_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_search(input int target, input int abort_k, input bit do_start);
    int p0;
    int exp_trial;
    p0 = n_preset;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      exp_trial = (target == 677) ? seq677[k] : trial(target, k);
      chk($sformatf("trial_t%0d_k%0d", target, k), ctrl_word, exp_trial * 8);
      chk("busy_search", busy, 1);
      chk("lf_en_search", lf_en, 0);
      // Noise on the detector and start lines while settling must be ignored.
      for (int j = 0; j < SC; j++) begin
        fd_valid = 1'($urandom % 2);
        fd_fast  = 1'($urandom % 2);
        start    = 1'($urandom % 2);
        tick();
      end
      fd_valid = 1'b0;
      start    = 1'b0;
      if (k == abort_k) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      tick();
      tick();
      fd_valid = 1'b1;
      fd_fast  = (int'(ctrl_word[12:3]) > target);
      tick();
      fd_valid = 1'b0;
    end
    chk("preset_pulse", lf_preset, 1);
    chk("preset_val", lf_preset_val, target * 8);
    chk("lf_en_track", lf_en, 1);
    chk("busy_track", busy, 0);
    chk("preset_count", n_preset - p0, 1);
  endtask

  task automatic track_follow(input int n);
    int lw;
    for (int i = 0; i < n; i++) begin
      lw = $urandom_range(1, 8190);
      lf_word = 13'(lw);
      start = 1'($urandom % 2);
      tick();
      start = 1'b0;
      chk("track_follow", ctrl_word, lw);
      chk("track_lf_en", lf_en, 1);
      chk("track_busy", busy, 0);
    end
    lf_word = 13'd100;
  endtask

  // Lock model: locked once the last LC samples since entry have all alternated; sticky.
  task automatic lock_seq();
    bit hist[$];
    bit lk_exp;
    bit alt;
    int gap;
    lk_exp = 1'b0;
    foreach (pat_q[s]) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("locked_gap", locked, lk_exp);
      end
      fd_valid = 1'b1;
      fd_fast  = pat_q[s];
      tick();
      fd_valid = 1'b0;
      hist.push_back(pat_q[s]);
      alt = (hist.size() >= LC);
      if (alt) begin
        for (int i = hist.size() - LC + 1; i < hist.size(); i++)
          if (hist[i] == hist[i-1]) alt = 1'b0;
      end
      lk_exp = lk_exp | alt;
      chk($sformatf("locked_s%0d", s), locked, lk_exp);
    end
  endtask

  initial begin
    bit pv;
    seq677 = '{512, 768, 640, 704, 672, 688, 680, 676, 678, 677};
    vecs[0] = '{677, 5416};
    vecs[1] = '{0, 0};
    vecs[2] = '{1023, 8184};
    vecs[3] = '{1, 8};
    vecs[4] = '{512, 4096};
    for (int i = 5; i < 8; i++) begin
      vecs[i].target = $urandom_range(0, 1023);
      vecs[i].exp_preset = vecs[i].target * 8;
    end

    tick();
    tick();
    rst = 1'b0;
    chk_reset("reset");
    tick();
    chk_reset("idle_hold");

    for (int v = 0; v < 8; v++) begin
      do_reset();
      chk_reset("pre_search");
      run_search(vecs[v].target, -1, 1'b1);
      chk("vec_preset", lf_preset_val, vecs[v].exp_preset);
      tick();
      chk("preset_one_cycle", lf_preset, 0);
      track_follow(4);
      pat_q.delete();
      if (v == 0) begin
        for (int i = 0; i < LC; i++) pat_q.push_back(bit'(i % 2));
      end else if (v == 1) begin
        pat_q = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0};
      end else begin
        pv = 1'($urandom % 2);
        for (int i = 0; i < 20; i++) begin
          pv = ($urandom % 4 != 0) ? ~pv : pv;
          pat_q.push_back(pv);
        end
      end
      lock_seq();
`ifdef DCO_LOCK_RELOCK_EN
      if (v == 0) begin
        chk("relock_pre_locked", locked, 1);
        lf_word = 13'd8191;
        tick();
        lf_word = 13'd100;
        chk("relock_locked", locked, 0);
        chk("relock_ctrl", ctrl_word, 4096);
        chk("relock_lf_en", lf_en, 0);
        run_search(vecs[0].target, -1, 1'b0);
      end
`endif
    end

    // Reset in the middle of the search, while measuring bit 5.
    do_reset();
    begin
      int p0;
      p0 = n_preset;
      run_search(333, 4, 1'b1);
      chk_reset("mid_reset");
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("mid_reset_idle_busy", busy, 0);
      end
      chk("mid_reset_no_preset", n_preset - p0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
